oob_detector: RTL and testbench

- Classifies SATA out-of-band (OOB) signalling from the receiver squelch/electrical-idle indication.
- Sits directly downstream of the signal edge detector that watches the idle level. Consumes its rise indication (burst end, line goes idle) and fall indication (burst start, line leaves idle).
- Times bursts and gaps and emits one-cycle COMINIT/COMRESET and COMWAKE detect pulses to the link-initialisation FSM.

---
 rtl/oob_detector.sv | 153 +++++++++++++++
 tb/tb_oob_detector.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/oob_detector.sv
// SATA out-of-band detector: times bursts and gaps on the squelch/idle edges
// and raises one-cycle COMINIT/COMRESET or COMWAKE pulses once a full train
// of equally classified gaps has been collected.
module oob_detector #(
  parameter int CW        = 8,
  parameter int BURSTS    = 4,
  parameter int WAKE_MIN  = 9,
  parameter int WAKE_MAX  = 26,
  parameter int INIT_MIN  = 27,
  parameter int INIT_MAX  = 78,
  parameter int BURST_MAX = 40
) (
  input  logic clk,
  input  logic reset,
  input  logic i_idle_rise,
  input  logic i_idle_fall,
  output logic o_cominit,
  output logic o_comwake,
  output logic o_active
);

  // A gap must never qualify for both classes, and every threshold must be
  // representable in the cycle counter.
  if (WAKE_MAX >= INIT_MIN) begin : g_bad_classes
    $error("oob_detector: WAKE_MAX must be below INIT_MIN");
  end
  if (BURSTS < 2 || BURSTS > 15) begin : g_bad_bursts
    $error("oob_detector: BURSTS must be in 2..15");
  end
  if (INIT_MAX >= (1 << CW) || BURST_MAX >= (1 << CW)) begin : g_bad_width
    $error("oob_detector: thresholds must fit in CW bits");
  end

  localparam logic [CW-1:0] WMIN = CW'(WAKE_MIN);
  localparam logic [CW-1:0] WMAX = CW'(WAKE_MAX);
  localparam logic [CW-1:0] IMIN = CW'(INIT_MIN);
  localparam logic [CW-1:0] IMAX = CW'(INIT_MAX);
  localparam logic [CW-1:0] BMAX = CW'(BURST_MAX);
  localparam logic [3:0]    LAST = 4'(BURSTS - 1);

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx, cnt_inc;
  logic [3:0]    wake_n, wake_nx, wake_inc;
  logic [3:0]    init_n, init_nx, init_inc;
  logic          cominit_nx, comwake_nx;
  logic          fall, rise;

  // Coincident rise and fall is a glitch and decodes to neither edge.
  assign fall     = i_idle_fall & ~i_idle_rise;
  assign rise     = i_idle_rise & ~i_idle_fall;
  assign cnt_inc  = (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;
  assign wake_inc = wake_n + 4'd1;
  assign init_inc = init_n + 4'd1;

  // Next-state, counter and detect decode.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    wake_nx    = wake_n;
    init_nx    = init_n;
    cominit_nx = 1'b0;
    comwake_nx = 1'b0;
    case (state)
      WAIT: begin
        if (fall) begin
          state_nx = BURST;
          cnt_nx   = '0;
        end
      end
      BURST: begin
        cnt_nx = cnt_inc;
        if (rise && cnt <= BMAX) begin
          state_nx = GAP;
          cnt_nx   = '0;
        end else if (cnt > BMAX) begin
          // Burst too long to be OOB signalling: drop the partial train.
          state_nx = WAIT;
          cnt_nx   = '0;
          wake_nx  = '0;
          init_nx  = '0;
        end
      end
      GAP: begin
        cnt_nx = cnt_inc;
        if (fall) begin
          // The fall always opens a burst, whatever the gap turned out to be.
          state_nx = BURST;
          cnt_nx   = '0;
          if (cnt >= WMIN && cnt <= WMAX) begin
            init_nx = '0;
            if (wake_inc == LAST) begin
              comwake_nx = 1'b1;
              wake_nx    = '0;
            end else begin
              wake_nx = wake_inc;
            end
          end else if (cnt >= IMIN && cnt <= IMAX) begin
            wake_nx = '0;
            if (init_inc == LAST) begin
              cominit_nx = 1'b1;
              init_nx    = '0;
            end else begin
              init_nx = init_inc;
            end
          end else begin
            wake_nx = '0;
            init_nx = '0;
          end
        end else if (cnt > IMAX) begin
          // Idle for longer than any legal gap: the train is over.
          state_nx = WAIT;
          cnt_nx   = '0;
          wake_nx  = '0;
          init_nx  = '0;
        end
      end
      default: begin
        state_nx = WAIT;
        cnt_nx   = '0;
        wake_nx  = '0;
        init_nx  = '0;
      end
    endcase
  end

  // State, counters and registered outputs; reset discards any partial train.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= WAIT;
      cnt       <= '0;
      wake_n    <= '0;
      init_n    <= '0;
      o_cominit <= 1'b0;
      o_comwake <= 1'b0;
      o_active  <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      wake_n    <= wake_nx;
      init_n    <= init_nx;
      o_cominit <= cominit_nx;
      o_comwake <= comwake_nx;
      o_active  <= (state_nx != WAIT);
    end
  end

endmodule

// File: tb/tb_oob_detector.sv
// Scoreboard bench for oob_detector: the driver queues each expected detect
// pulse with its cycle, and a negedge monitor matches every pulse the DUT emits.
module tb_oob_detector;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic i_idle_rise = 1'b0;
  logic i_idle_fall = 1'b0;
  logic o_cominit, o_comwake, o_active;

  typedef struct {
    bit is_wake;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;

  oob_detector dut (
    .clk        (clk),
    .reset      (reset),
    .i_idle_rise(i_idle_rise),
    .i_idle_fall(i_idle_fall),
    .o_cominit  (o_cominit),
    .o_comwake  (o_comwake),
    .o_active   (o_active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (o_cominit && o_comwake) begin
      checks++;
      $display("FAIL both_pulses cyc=%0d cominit=%0b comwake=%0b required not both", cyc, o_cominit, o_comwake);
    end else if (o_cominit || o_comwake) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_pulse cyc=%0d comwake=%0b cominit=%0b required none", cyc, o_comwake, o_cominit);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (o_comwake != e.is_wake || cyc != e.cyc)
          $display("FAIL pulse cyc=%0d comwake=%0b required cyc=%0d comwake=%0b", cyc, o_comwake, e.cyc, e.is_wake);
        else
          passed++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) $display("FAIL %s got=%0b required=%0b", name, act, req);
    else passed++;
  endtask

  task automatic chk_at_negedge(input string name, input logic req_active);
    @(negedge clk);
    chk(name, o_active, req_active);
  endtask

  task automatic drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL %s pending_pulses=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end else begin
      passed++;
    end
  endtask

  // Fall pulse, b quiet cycles (counter reaches b), then rise pulse.
  task automatic burst(input int b, input bit exp_pulse, input bit is_wake);
    exp_t e;
    if (exp_pulse) begin
      e.is_wake = is_wake;
      e.cyc     = cyc + 1;
      exp_q.push_back(e);
    end
    i_idle_fall = 1'b1;
    tick();
    i_idle_fall = 1'b0;
    repeat (b) tick();
    i_idle_rise = 1'b1;
    tick();
    i_idle_rise = 1'b0;
  endtask

  // Quiet cycles after a rise: the next fall sees a gap of g.
  task automatic gap(input int g);
    repeat (g) tick();
  endtask

  task automatic train4(input string name, input int b, input int g1, input int g2, input int g3,
                        input bit exp_pulse, input bit is_wake);
    burst(b, 0, 0); gap(g1);
    burst(b, 0, 0); gap(g2);
    burst(b, 0, 0); gap(g3);
    burst(b, exp_pulse, is_wake);
    gap(100);
    drained(name);
  endtask

  initial begin
    // Reset state
    #2 reset = 1'b0;
    #1;
    chk("reset_active", o_active, 1'b0);
    chk("reset_cominit", o_cominit, 1'b0);
    chk("reset_comwake", o_comwake, 1'b0);
    repeat (3) tick();
    reset = 1'b1;
    gap(200);
    chk_at_negedge("idle_active", 1'b0);

    // COMINIT train with o_active timing around the final timeout
    burst(16, 0, 0); gap(48);
    chk_at_negedge("active_in_gap", 1'b1);
    burst(16, 0, 0); gap(48);
    burst(16, 0, 0); gap(48);
    burst(16, 1, 0);
    gap(79);
    chk_at_negedge("active_before_timeout", 1'b1);
    tick();
    chk_at_negedge("active_after_timeout", 1'b0);
    gap(20);
    drained("cominit_train");

    // COMWAKE train
    train4("comwake_train", 16, 16, 16, 16, 1, 1);

    // Gap boundaries
    train4("gap8", 16, 8, 8, 8, 0, 0);
    train4("gap9", 16, 9, 9, 9, 1, 1);
    train4("gap26", 16, 26, 26, 26, 1, 1);
    train4("gap27", 16, 27, 27, 27, 1, 0);
    train4("gap78", 16, 78, 78, 78, 1, 0);
    train4("gap79", 16, 79, 79, 79, 0, 0);

    // Mixed classes reset each other
    train4("mixed", 16, 48, 16, 48, 0, 0);

    // Longest legal burst
    train4("burst40", 40, 48, 48, 48, 1, 0);

    // Over-long burst aborts the train, a fresh train then detects
    burst(16, 0, 0); gap(48);
    burst(16, 0, 0); gap(48);
    burst(41, 0, 0);
    chk_at_negedge("active_after_long_burst", 1'b0);
    gap(48);
    burst(16, 0, 0);
    gap(100);
    drained("long_burst_abort");
    train4("after_abort", 16, 48, 48, 48, 1, 0);

    // Coincident rise+fall inside a gap is ignored
    burst(16, 0, 0); gap(48);
    burst(16, 0, 0); gap(20);
    i_idle_rise = 1'b1;
    i_idle_fall = 1'b1;
    tick();
    i_idle_rise = 1'b0;
    i_idle_fall = 1'b0;
    gap(27);
    burst(16, 0, 0); gap(48);
    burst(16, 1, 0);
    gap(100);
    drained("glitch_ignored");

    // Asynchronous reset mid-train discards the partial sequence
    burst(16, 0, 0); gap(48);
    burst(16, 0, 0); gap(48);
    burst(16, 0, 0); gap(20);
    reset = 1'b0;
    #1;
    chk("async_reset_active", o_active, 1'b0);
    tick();
    reset = 1'b1;
    gap(27);
    burst(16, 0, 0);
    gap(100);
    drained("reset_mid_train");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
